// File: rtl/nn_param_fetch.sv
// Parameter-memory read sequencer: bias read, then credit-gated 4-word weight bursts per input index into an output FIFO.
// Optional bias path is enabled by defining PARAM_FETCH_BIAS_EN.
module nn_param_fetch #(
  parameter int NUM_I      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  n_sel,
  output logic        weight_en,
  output logic        bias_en,
  output logic [5:0]  n,
  output logic [5:0]  i,
  input  logic [15:0] wt_data,
  input  logic [15:0] bias_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_wt,
  output logic [1:0]  out_k,
  output logic [5:0]  out_i,
  output logic        out_last,
  output logic [15:0] out_bias,
  output logic        bias_valid,
  output logic        busy,
  output logic        done
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, BIAS_RD, BURST, WAIT_SPACE, DRAIN} state_t;
  typedef struct packed {
    logic [15:0] wt;
    logic [1:0]  k;
    logic [5:0]  i;
    logic        last;
  } word_t;

  state_t          state, state_nxt;
  logic [5:0]      n_q, i_q;
  logic [1:0]      k_q;
  logic            wr_vld;
  logic [1:0]      wr_k;
  logic [5:0]      wr_i;
  word_t           fifo_mem [FIFO_DEPTH];
  word_t           head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [AW+1:0]   used;
  logic            fire, has_room, last_burst;

  assign fire       = out_valid & out_ready;
  assign last_burst = (i_q == 6'(NUM_I - 1));
  // Slots owed: words stored, the word landing now, and the word being enabled now.
  assign used       = (AW+2)'(count) + (AW+2)'(wr_vld) + (AW+2)'(weight_en);
  assign has_room   = (used <= (AW+2)'(FIFO_DEPTH - 4));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) begin
`ifdef PARAM_FETCH_BIAS_EN
        state_nxt = BIAS_RD;
`else
        state_nxt = has_room ? BURST : WAIT_SPACE;
`endif
      end
`ifdef PARAM_FETCH_BIAS_EN
      BIAS_RD:    state_nxt = has_room ? BURST : WAIT_SPACE;
`endif
      BURST: if (k_q == 2'd3) begin
        if (last_burst)     state_nxt = DRAIN;
        else if (!has_room) state_nxt = WAIT_SPACE;
      end
      WAIT_SPACE: if (has_room) state_nxt = BURST;
      DRAIN:      if (fire && head.last) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      n_q    <= '0;
      i_q    <= '0;
      k_q    <= '0;
      wr_vld <= 1'b0;
      wr_k   <= '0;
      wr_i   <= '0;
    end else begin
      state  <= state_nxt;
      wr_vld <= weight_en;
      wr_k   <= k_q;
      wr_i   <= i_q;
      if (state == IDLE && start) begin
        n_q <= n_sel;
        i_q <= '0;
      end
      // k_q tracks the memory's internal burst counter, which clears when weight_en drops
      if (weight_en) begin
        k_q <= k_q + 2'd1;
        if (k_q == 2'd3) i_q <= i_q + 6'd1;
      end else begin
        k_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_vld)
      fifo_mem[wr_ptr] <= '{wt: wt_data, k: wr_k, i: wr_i,
                            last: (wr_i == 6'(NUM_I - 1)) && (wr_k == 2'd3)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_vld) wr_ptr <= wr_ptr + AW'(1);
      if (fire)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_vld, fire})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign head      = fifo_mem[rd_ptr];
  assign out_valid = (count != '0);
  assign out_wt    = out_valid ? head.wt   : '0;
  assign out_k     = out_valid ? head.k    : '0;
  assign out_i     = out_valid ? head.i    : '0;
  assign out_last  = out_valid & head.last;
  assign done      = (state == DRAIN) & fire & head.last;
  assign busy      = (state != IDLE);
  assign weight_en = (state == BURST);
  assign n         = n_q;
  assign i         = i_q;

`ifdef PARAM_FETCH_BIAS_EN
  logic        bias_ld, bias_vld_q;
  logic [15:0] bias_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bias_ld    <= 1'b0;
      bias_vld_q <= 1'b0;
      bias_q     <= '0;
    end else begin
      bias_ld <= (state == BIAS_RD);
      if (state == IDLE && start) bias_vld_q <= 1'b0;
      else if (state == BIAS_RD)  bias_vld_q <= 1'b1;
      if (bias_ld) bias_q <= bias_data;
    end
  end

  // bias_data is live only in the load cycle; bypass it so out_bias is usable right away
  assign bias_en    = (state == BIAS_RD);
  assign out_bias   = bias_ld ? bias_data : bias_q;
  assign bias_valid = bias_vld_q;
`else
  logic unused_bias;
  assign unused_bias = ^bias_data;
  assign bias_en     = 1'b0;
  assign out_bias    = '0;
  assign bias_valid  = 1'b0;
`endif

endmodule
